// File: rtl/bcd_serial_addsub.sv
// Digit-serial packed-BCD adder/subtractor: one decimal digit per clock, LSD first.
// Subtraction adds the nine's complement of B with carry-in 1.
module bcd_serial_addsub #(
    parameter int unsigned NDIGITS = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [4*NDIGITS-1:0]   a,
    input  logic [4*NDIGITS-1:0]   b,
    input  logic                   op,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [4*NDIGITS-1:0]   sum,
    output logic                   cout,
    output logic                   err
);

    localparam int unsigned W    = 4 * NDIGITS;
    localparam int unsigned CNTW = (NDIGITS > 2) ? $clog2(NDIGITS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [W-1:0]      a_sr, b_sr, res_sr;
    logic              op_r, carry, err_r;
    logic [CNTW-1:0]   cnt;

    logic              accept, last, release_res;
    logic              bad_in;
    logic [3:0]        bd, digit;
    logic [4:0]        t;
    logic              carry_nxt;

    assign in_ready    = (state == IDLE);
    assign accept      = (state == IDLE) && in_valid;
    assign last        = (state == CALC) && (cnt == CNTW'(NDIGITS - 1));
    assign release_res = (state == DONE) && out_ready;

    always_comb begin
        bad_in = 1'b0;
        for (int unsigned i = 0; i < NDIGITS; i++) begin
            if (a[4*i +: 4] > 4'd9 || b[4*i +: 4] > 4'd9)
                bad_in = 1'b1;
        end
    end

    // One BCD digit step on the low nibbles of the shift registers.
    always_comb begin
        bd = op_r ? (4'd9 - b_sr[3:0]) : b_sr[3:0];
        t  = {1'b0, a_sr[3:0]} + {1'b0, bd} + {4'd0, carry};
        if (t > 5'd9) begin
            digit     = 4'(t + 5'd6);
            carry_nxt = 1'b1;
        end else begin
            digit     = t[3:0];
            carry_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)  state_nxt = CALC;
            CALC:    if (last)      state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sr      <= '0;
            b_sr      <= '0;
            res_sr    <= '0;
            op_r      <= 1'b0;
            carry     <= 1'b0;
            err_r     <= 1'b0;
            cnt       <= '0;
            sum       <= '0;
            cout      <= 1'b0;
            err       <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            if (accept) begin
                a_sr  <= a;
                b_sr  <= b;
                op_r  <= op;
                carry <= op;
                err_r <= bad_in;
                cnt   <= '0;
            end else if (state == CALC) begin
                a_sr   <= {4'd0, a_sr[W-1:4]};
                b_sr   <= {4'd0, b_sr[W-1:4]};
                res_sr <= {digit, res_sr[W-1:4]};
                carry  <= carry_nxt;
                cnt    <= cnt + CNTW'(1);
                if (last) begin
                    out_valid <= 1'b1;
                    err       <= err_r;
                    if (err_r) begin
                        sum  <= '0;
                        cout <= 1'b0;
                    end else begin
                        sum  <= {digit, res_sr[W-1:4]};
                        cout <= op_r ? ~carry_nxt : carry_nxt;
                    end
                end
            end else if (release_res) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_bcd_serial_addsub.sv
// Directed bench for bcd_serial_addsub (NDIGITS=4) with hand-computed BCD results.
module tb_bcd_serial_addsub;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        op = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] sum;
    logic        cout;
    logic        err;

    int total = 0;
    int bad   = 0;

    bcd_serial_addsub #(.NDIGITS(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Accept one operation and wait for the result; leaves the DUT in DONE.
    task automatic run_op(input logic [15:0] av, input logic [15:0] bv, input logic opv,
                          input logic [15:0] es, input logic ec, input logic ee, input string tag);
        int cyc;
        @(negedge clk);
        a = av; b = bv; op = opv; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = 16'h9999; b = 16'h8888; op = ~opv;
        check({tag, "_busy"}, {31'd0, in_ready}, 32'd0);
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, "_lat"}, cyc, 32'd4);
        check({tag, "_sum"}, {16'd0, sum}, {16'd0, es});
        check({tag, "_cout"}, {31'd0, cout}, {31'd0, ec});
        check({tag, "_err"}, {31'd0, err}, {31'd0, ee});
    endtask

    task automatic release_result(input string tag);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_ovlow"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_rdy"}, {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        int seen;
        #2;
        check("rst_rdy",  {31'd0, in_ready},  32'd1);
        check("rst_ov",   {31'd0, out_valid}, 32'd0);
        check("rst_sum",  {16'd0, sum},       32'd0);
        check("rst_cout", {31'd0, cout},      32'd0);
        check("rst_err",  {31'd0, err},       32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op(16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0, "add1");
        release_result("add1");
        run_op(16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, "ripple");
        release_result("ripple");
        run_op(16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, "zero");
        release_result("zero");
        run_op(16'h0500, 16'h0123, 1'b1, 16'h0377, 1'b0, 1'b0, "sub1");
        release_result("sub1");
        run_op(16'h0123, 16'h0500, 1'b1, 16'h9623, 1'b1, 1'b0, "sub2");
        release_result("sub2");
        run_op(16'h4321, 16'h4321, 1'b1, 16'h0000, 1'b0, 1'b0, "subeq");
        release_result("subeq");
        run_op(16'h12A4, 16'h0001, 1'b0, 16'h0000, 1'b0, 1'b1, "baddig");
        release_result("baddig");
        run_op(16'h0005, 16'h0005, 1'b0, 16'h0010, 1'b0, 1'b0, "after_err");
        release_result("after_err");

        // Hold the result in DONE while in_valid pulses are offered.
        run_op(16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0, "hold");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            a = 16'h1111; b = 16'h2222; in_valid = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0;
            check("hold_ov",   {31'd0, out_valid}, 32'd1);
            check("hold_sum",  {16'd0, sum},       32'h6912);
            check("hold_cout", {31'd0, cout},      32'd0);
            check("hold_rdy",  {31'd0, in_ready},  32'd0);
        end
        release_result("hold");
        run_op(16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0, 1'b0, "next");
        release_result("next");

        // Abort mid-computation with reset at cnt==2.
        @(negedge clk);
        a = 16'h5555; b = 16'h5555; op = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("abort_ov",   {31'd0, out_valid}, 32'd0);
        check("abort_rdy",  {31'd0, in_ready},  32'd1);
        check("abort_sum",  {16'd0, sum},       32'd0);
        check("abort_cout", {31'd0, cout},      32'd0);
        check("abort_err",  {31'd0, err},       32'd0);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        check("abort_noov", seen, 32'd0);
        run_op(16'h0042, 16'h0058, 1'b0, 16'h0100, 1'b0, 1'b0, "post_rst");
        release_result("post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
